// File: rtl/chamber_ctrl.sv
// Lock-chamber level controller: tracks a discrete water level filled/drained in
// tick-paced steps, supports reversal and hold, and decodes gate permits from state.
module chamber_ctrl #(
    parameter int LEVELS     = 4,
    parameter int FILL_STEP  = 7,
    parameter int DRAIN_STEP = 8,
    parameter int LVL_W      = 8,
    parameter int STEP_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             fill,
    input  logic             empty,
    input  logic             hold,
    output logic [1:0]       state,
    output logic [LVL_W-1:0] level,
    output logic             status,
    output logic             busy,
    output logic             done,
    output logic             low_gate_ok,
    output logic             high_gate_ok
);

    typedef enum logic [1:0] {
        EMPT = 2'b00,
        FING = 2'b01,
        FULL = 2'b10,
        EING = 2'b11
    } state_t;

    localparam logic [LVL_W-1:0]  LVL_ONE    = LVL_W'(1);
    localparam logic [LVL_W-1:0]  LVL_TOP    = LVL_W'(LEVELS - 1);
    localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);
    localparam logic [STEP_W-1:0] FILL_LAST  = STEP_W'(FILL_STEP - 1);
    localparam logic [STEP_W-1:0] DRAIN_LAST = STEP_W'(DRAIN_STEP - 1);

    state_t            st;
    logic [STEP_W-1:0] step;
    logic              adv;

    assign adv = tick & ~hold;

    // Reversal is checked before the tick so it wins even while hold is high,
    // and always discards the partial step.
    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= EMPT;
            level <= '0;
            step  <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                EMPT: begin
                    if (fill && !empty) begin
                        st   <= FING;
                        step <= '0;
                    end
                end
                FING: begin
                    if (empty && !fill) begin
                        st   <= EING;
                        step <= '0;
                    end else if (adv) begin
                        if (step == FILL_LAST) begin
                            step  <= '0;
                            level <= level + LVL_ONE;
                            if (level == LVL_TOP) begin
                                st   <= FULL;
                                done <= 1'b1;
                            end
                        end else begin
                            step <= step + STEP_ONE;
                        end
                    end
                end
                FULL: begin
                    if (empty && !fill) begin
                        st   <= EING;
                        step <= '0;
                    end
                end
                EING: begin
                    if (fill && !empty) begin
                        st   <= FING;
                        step <= '0;
                    end else if (adv) begin
                        if (step == DRAIN_LAST) begin
                            step  <= '0;
                            level <= level - LVL_ONE;
                            if (level == LVL_ONE) begin
                                st   <= EMPT;
                                done <= 1'b1;
                            end
                        end else begin
                            step <= step + STEP_ONE;
                        end
                    end
                end
                default: begin
                    st    <= EMPT;
                    level <= '0;
                    step  <= '0;
                end
            endcase
        end
    end

    assign state        = st;
    assign status       = (st == FULL);
    assign busy         = (st == FING) || (st == EING);
    assign low_gate_ok  = (st == EMPT);
    assign high_gate_ok = (st == FULL);

endmodule

// File: tb/tb_chamber_ctrl.sv
// Directed bench for chamber_ctrl: the driver queues expected snapshots and done
// events; a negedge monitor pops and compares them against the DUT outputs.
module tb_chamber_ctrl;

    localparam logic [1:0] S_EMPT = 2'b00;
    localparam logic [1:0] S_FING = 2'b01;
    localparam logic [1:0] S_FULL = 2'b10;
    localparam logic [1:0] S_EING = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b1;
    logic       fill = 1'b0;
    logic       empty = 1'b0;
    logic       hold = 1'b0;
    logic [1:0] state;
    logic [7:0] level;
    logic       status, busy, done, low_gate_ok, high_gate_ok;

    logic [14:0] exp_q[$];
    string       name_q[$];
    logic [9:0]  done_q[$];
    logic        sample_req = 1'b0;
    logic        final_req = 1'b0;
    int          checks = 0;
    int          errors = 0;

    chamber_ctrl dut (
        .clk(clk), .rst(rst), .tick(tick), .fill(fill), .empty(empty), .hold(hold),
        .state(state), .level(level), .status(status), .busy(busy), .done(done),
        .low_gate_ok(low_gate_ok), .high_gate_ok(high_gate_ok)
    );

    always #5 clk = ~clk;

    // Snapshot layout: {state, level, status, busy, done, low_gate_ok, high_gate_ok}
    function automatic logic [14:0] mk(input logic [1:0] s, input logic [7:0] l, input logic d);
        mk = {s, l, s == S_FULL, (s == S_FING) || (s == S_EING), d, s == S_EMPT, s == S_FULL};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        sample_req = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [1:0] s, input logic [7:0] l, input logic d);
        exp_q.push_back(mk(s, l, d));
        name_q.push_back(nm);
        sample_req = 1'b1;
    endtask

    task automatic expect_done(input logic [1:0] s, input logic [7:0] l);
        done_q.push_back({s, l});
    endtask

    always @(negedge clk) begin
        logic [14:0] act;
        logic [14:0] exp;
        logic [9:0]  dexp;
        string       nm;
        act = {state, level, status, busy, done, low_gate_ok, high_gate_ok};
        if (sample_req) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL snapshot: sample with empty queue, got %h", act);
            end else begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
                end
            end
        end
        if (done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL done_pulse: unexpected done, state=%0d level=%0d (t=%0t)", state, level, $time);
            end else begin
                dexp = done_q.pop_front();
                if ({state, level} !== dexp) begin
                    errors++;
                    $display("FAIL done_pulse: got %h expected %h", {state, level}, dexp);
                end
            end
        end
        if (final_req) begin
            checks++;
            if (exp_q.size() != 0 || done_q.size() != 0) begin
                errors++;
                $display("FAIL drain_queues: %0d snapshots and %0d done events left, expected 0",
                         exp_q.size(), done_q.size());
            end
        end
    end

    initial begin
        repeat (2) cyc();
        chk("reset", S_EMPT, 8'd0, 1'b0);
        rst = 1'b0;
        cyc();

        // Full fill with tick every cycle
        fill = 1'b1;
        cyc();
        fill = 1'b0;
        chk("fill_start", S_FING, 8'd0, 1'b0);
        repeat (6) cyc();
        chk("fill_k6", S_FING, 8'd0, 1'b0);
        cyc();
        chk("fill_k7", S_FING, 8'd1, 1'b0);
        repeat (20) cyc();
        chk("fill_k27", S_FING, 8'd3, 1'b0);
        expect_done(S_FULL, 8'd4);
        cyc();
        chk("fill_full", S_FULL, 8'd4, 1'b1);
        cyc();
        chk("full_after", S_FULL, 8'd4, 1'b0);

        // Full drain
        empty = 1'b1;
        cyc();
        empty = 1'b0;
        chk("drain_start", S_EING, 8'd4, 1'b0);
        repeat (7) cyc();
        chk("drain_k7", S_EING, 8'd4, 1'b0);
        cyc();
        chk("drain_k8", S_EING, 8'd3, 1'b0);
        repeat (23) cyc();
        chk("drain_k31", S_EING, 8'd1, 1'b0);
        expect_done(S_EMPT, 8'd0);
        cyc();
        chk("drain_empty", S_EMPT, 8'd0, 1'b1);
        cyc();
        chk("empty_after", S_EMPT, 8'd0, 1'b0);

        // Reversal at level 2, step 3
        fill = 1'b1;
        cyc();
        fill = 1'b0;
        repeat (17) cyc();
        chk("rev_pre", S_FING, 8'd2, 1'b0);
        empty = 1'b1;
        cyc();
        empty = 1'b0;
        chk("rev_eing", S_EING, 8'd2, 1'b0);
        repeat (15) cyc();
        chk("rev_k15", S_EING, 8'd1, 1'b0);
        expect_done(S_EMPT, 8'd0);
        cyc();
        chk("rev_empty", S_EMPT, 8'd0, 1'b1);

        // Hold freezes step, then tick only every third cycle
        fill = 1'b1;
        cyc();
        fill = 1'b0;
        repeat (5) cyc();
        hold = 1'b1;
        repeat (10) cyc();
        chk("hold_frozen", S_FING, 8'd0, 1'b0);
        hold = 1'b0;
        cyc();
        chk("hold_rel1", S_FING, 8'd0, 1'b0);
        cyc();
        chk("hold_rel2", S_FING, 8'd1, 1'b0);
        expect_done(S_FULL, 8'd4);
        for (int i = 0; i < 21; i++) begin
            if (i == 20) chk("gated_k27", S_FING, 8'd3, 1'b0);
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
            cyc();
        end
        tick = 1'b1;
        chk("gated_full", S_FULL, 8'd4, 1'b0);

        // Conflicting and redundant requests in FULL
        fill = 1'b1;
        empty = 1'b1;
        repeat (2) cyc();
        chk("full_conflict", S_FULL, 8'd4, 1'b0);
        empty = 1'b0;
        repeat (3) cyc();
        chk("full_fill_noop", S_FULL, 8'd4, 1'b0);
        fill = 1'b0;

        // Drain to level 2, reverse twice under hold, then reset mid-drain
        empty = 1'b1;
        cyc();
        empty = 1'b0;
        repeat (16) cyc();
        chk("mid_lvl2", S_EING, 8'd2, 1'b0);
        hold = 1'b1;
        fill = 1'b1;
        cyc();
        fill = 1'b0;
        chk("hold_rev_fill", S_FING, 8'd2, 1'b0);
        empty = 1'b1;
        cyc();
        empty = 1'b0;
        chk("hold_rev_drain", S_EING, 8'd2, 1'b0);
        hold = 1'b0;
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_reset", S_EMPT, 8'd0, 1'b0);

        // Conflicting request in EMPT
        fill = 1'b1;
        empty = 1'b1;
        repeat (2) cyc();
        chk("empt_conflict", S_EMPT, 8'd0, 1'b0);
        fill = 1'b0;
        empty = 1'b0;
        repeat (2) cyc();

        final_req = 1'b1;
        cyc();
        final_req = 1'b0;
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
